// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the core.
// The fetch unit takes the master view; memory and core together take the slave view.
interface instruction_fetch_unit_if #(
  parameter int IBUS = 32,
  parameter int ABUS = 32
);
  logic            imem_req;
  logic [ABUS-1:0] imem_addr;
  logic            imem_valid;
  logic [IBUS-1:0] imem_data;
  logic [IBUS-1:0] instruction;
  logic [ABUS-1:0] pcDir;
  logic            inst_valid;
  logic            stall;
  logic            redirect;
  logic [ABUS-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instruction, pcDir, inst_valid,
    input  imem_valid, imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, pcDir, inst_valid,
    output imem_valid, imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-beat memory requests and buffers
// returned words with their PC in a small prefetch FIFO that feeds the core.
module instruction_fetch_unit #(
  parameter int              IBUS     = 32,
  parameter int              ABUS     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ABUS-1:0] RESET_PC = '0
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  state_t          state, state_next;
  logic [ABUS-1:0] fetch_pc;
  logic [ABUS-1:0] req_pc;
  logic [ABUS-1:0] target_pc;

  logic [IBUS-1:0] fifo_instr [DEPTH];
  logic [ABUS-1:0] fifo_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;

  logic issue, push, pop, full, empty;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign target_pc = {bus.redirect_pc[ABUS-1:2], 2'b00};

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && !bus.redirect && !full) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // A redirect racing the response drops it; otherwise the response is squashed later.
        if (bus.redirect)
          state_next = bus.imem_valid ? IDLE : FLUSH;
        else if (bus.imem_valid) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (bus.imem_valid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop = !empty && !bus.stall && !bus.redirect;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= target_pc;
    end else if (issue) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ABUS'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count alone decides which
  // entries are valid, and empty-state outputs are forced to zero below.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_data;
      fifo_pc[wr_ptr]    <= req_pc;
    end
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = issue ? fetch_pc : '0;
  assign bus.inst_valid  = !empty;
  assign bus.instruction = empty ? '0 : fifo_instr[rd_ptr];
  assign bus.pcDir       = empty ? '0 : fifo_pc[rd_ptr];

  // Issue is gated on free space, so a push into a full FIFO means broken bookkeeping.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && full));

  a_no_issue_on_redirect: assert property (@(posedge clk) disable iff (rst)
    !(issue && bus.redirect));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: a latency-programmable memory model plus an occupancy /
// address-stream reference model of the fetch stage, with directed and random steps.
module tb_instruction_fetch_unit;
  localparam int          IBUS     = 32;
  localparam int          ABUS     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam int C_INST_VALID = 0;
  localparam int C_REQ        = 1;
  localparam int C_MEM_VALID  = 2;
  localparam int C_BUSY_ENTRY = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.IBUS(IBUS), .ABUS(ABUS)) bus ();

  instruction_fetch_unit #(
    .IBUS(IBUS), .ABUS(ABUS), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data  = '0;
  logic        pend      = 1'b0;
  logic [31:0] paddr     = '0;
  int          rem       = 0;
  int          mem_lat   = 1;
  logic        stray      = 1'b0;
  logic [31:0] stray_data = '0;

  assign bus.imem_valid = mem_valid | stray;
  assign bus.imem_data  = stray ? stray_data : mem_data;

  // Reference model state
  int          occ;
  logic        live;
  logic [31:0] exp_fetch;
  logic [31:0] exp_pop;
  int          cyc;
  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_ins_q[$];
  int          pop_cyc_q[$];

  function automatic logic [31:0] tag(input logic [31:0] a);
    return 32'hD000_0000 ^ ((a >> 2) * 32'h1100_0000) ^ (a >> 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  // Memory: sample the request mid-cycle, answer mem_lat cycles later.
  initial begin
    logic        req_s;
    logic [31:0] addr_s;
    forever begin
      @(negedge clk);
      req_s  = !rst && bus.imem_req;
      addr_s = bus.imem_addr;
      @(posedge clk);
      #1;
      if (rst) begin
        pend      = 1'b0;
        mem_valid = 1'b0;
      end else begin
        if (req_s) begin
          pend  = 1'b1;
          rem   = mem_lat;
          paddr = addr_s;
        end
        mem_valid = 1'b0;
        if (pend) begin
          rem--;
          if (rem == 0) begin
            mem_valid = 1'b1;
            mem_data  = tag(paddr);
            pend      = 1'b0;
          end
        end
      end
    end
  end

  // One clock cycle: compare DUT against the model for the inputs now applied, then advance.
  task automatic tick();
    logic exp_req, pop_now, push_now;
    #1;
    exp_req = !rst && !pend && !mem_valid && (occ < DEPTH) && !bus.redirect;
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (bus.imem_req) begin
      req_addr_q.push_back(bus.imem_addr);
      req_cyc_q.push_back(cyc);
    end
    if (exp_req) chk("imem_addr", bus.imem_addr, exp_fetch);
    chk("inst_valid", 32'(bus.inst_valid), 32'(occ > 0));
    if (occ == 0) begin
      chk("pcDir_empty", bus.pcDir, 32'h0);
      chk("instruction_empty", bus.instruction, 32'h0);
    end else begin
      chk("pcDir_head", bus.pcDir, exp_pop);
      chk("instruction_head", bus.instruction, tag(exp_pop));
    end
    pop_now  = (occ > 0) && !bus.stall && !bus.redirect;
    push_now = mem_valid && live && !bus.redirect;
    if (pop_now) begin
      pop_pc_q.push_back(bus.pcDir);
      pop_ins_q.push_back(bus.instruction);
      pop_cyc_q.push_back(cyc);
      exp_pop += 32'd4;
    end
    if (bus.redirect) begin
      occ       = 0;
      live      = 1'b0;
      exp_fetch = {bus.redirect_pc[31:2], 2'b00};
      exp_pop   = exp_fetch;
    end else begin
      occ = occ + int'(push_now) - int'(pop_now);
      if (mem_valid) live = 1'b0;
      if (exp_req) begin
        live      = 1'b1;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      C_INST_VALID: return bus.inst_valid;
      C_REQ:        return bus.imem_req;
      C_MEM_VALID:  return mem_valid;
      default:      return bus.inst_valid && pend;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int budget);
    int n = 0;
    #1;
    while (!cond(sel) && n < budget) begin
      tick();
      #1;
      n++;
    end
    chk({name, "_reached"}, 32'(cond(sel)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_instruction", bus.instruction, 32'h0);
    chk("rst_pcDir", bus.pcDir, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst       = 1'b0;
    occ       = 0;
    live      = 1'b0;
    exp_fetch = RESET_PC;
    exp_pop   = RESET_PC;
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    pop_pc_q.delete();
    pop_ins_q.delete();
    pop_cyc_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    rst             = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    occ = 0; live = 1'b0; exp_fetch = RESET_PC; exp_pop = RESET_PC; cyc = 0;
    #1;

    // Step 1: streaming with 1-cycle memory
    do_reset();
    clear_logs();
    repeat (9) tick();
    chk("t1_nreq", req_addr_q.size(), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("t1_req_addr", req_addr_q[i], 32'(i * 4));
      if (i > 0) chk("t1_req_spacing", 32'(req_cyc_q[i] - req_cyc_q[i-1]), 32'd2);
    end
    chk("t1_pc0", pop_pc_q[0], 32'h0);
    chk("t1_ins0", pop_ins_q[0], 32'hD000_0000);
    chk("t1_pc1", pop_pc_q[1], 32'h4);
    chk("t1_ins1", pop_ins_q[1], 32'hC100_0000);
    chk("t1_valid_latency", 32'(pop_cyc_q[0] - req_cyc_q[0]), 32'd2);

    // Step 2: stall fills the FIFO and pauses issue
    do_reset();
    clear_logs();
    wait_for("t2_first_valid", C_INST_VALID, 10);
    bus.stall = 1'b1;
    repeat (10) tick();
    #1;
    chk("t2_req_paused", 32'(bus.imem_req), 32'd0);
    chk("t2_head_valid", 32'(bus.inst_valid), 32'd1);
    chk("t2_head_pc", bus.pcDir, 32'h0);
    bus.stall = 1'b0;
    tick();
    tick();
    chk("t2_npops", pop_pc_q.size(), 32'd2);
    chk("t2_pop0", pop_pc_q[0], 32'h0);
    chk("t2_pop1", pop_pc_q[1], 32'h4);
    chk("t2_pop_consecutive", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd1);
    #1;
    chk("t2_drained", 32'(bus.inst_valid), 32'd0);

    // Step 3: redirect during a slow fetch squashes the late response
    mem_lat = 3;
    do_reset();
    wait_for("t3_req", C_REQ, 5);
    tick();
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t3_late_resp_present", 32'(mem_valid), 32'd1);
    chk("t3_late_resp_hidden", 32'(bus.inst_valid), 32'd0);
    tick();
    #1;
    chk("t3_refetch_req", 32'(bus.imem_req), 32'd1);
    chk("t3_refetch_addr", bus.imem_addr, 32'h100);
    wait_for("t3_target_valid", C_INST_VALID, 10);
    chk("t3_first_pc", bus.pcDir, 32'h100);
    chk("t3_first_ins", bus.instruction, tag(32'h100));

    // Step 4: redirect coinciding with the response, unaligned target
    mem_lat = 1;
    wait_for("t4_resp", C_MEM_VALID, 10);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t4_fifo_empty", 32'(bus.inst_valid), 32'd0);
    chk("t4_req", 32'(bus.imem_req), 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h200);

    // Step 5: redirect with a full FIFO and no stall
    bus.stall = 1'b1;
    repeat (8) tick();
    #1;
    chk("t5_full_valid", 32'(bus.inst_valid), 32'd1);
    chk("t5_full_noreq", 32'(bus.imem_req), 32'd0);
    bus.stall       = 1'b0;
    tgt             = $urandom;
    bus.redirect    = 1'b1;
    bus.redirect_pc = tgt;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("t5_flushed", 32'(bus.inst_valid), 32'd0);
    chk("t5_req", 32'(bus.imem_req), 32'd1);
    chk("t5_addr", bus.imem_addr, {tgt[31:2], 2'b00});
    wait_for("t5_target_valid", C_INST_VALID, 10);
    chk("t5_first_pc", bus.pcDir, {tgt[31:2], 2'b00});

    // Random phase: stalls, redirects (some near the top of the address space), latencies
    for (int i = 0; i < 600; i++) begin
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else
        bus.redirect_pc = $urandom;
      mem_lat = $urandom_range(1, 4);
      tick();
    end
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;

    // Step 6: async reset while a request is outstanding, then a stray response
    mem_lat         = 3;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    bus.redirect = 1'b0;
    bus.stall    = 1'b1;
    wait_for("t6_busy_with_entry", C_BUSY_ENTRY, 20);
    do_reset();
    bus.stall  = 1'b0;
    clear_logs();
    stray      = 1'b1;
    stray_data = 32'hDEAD_BEEF;
    tick();
    stray = 1'b0;
    chk("t6_first_req_addr", req_addr_q[0], RESET_PC);
    wait_for("t6_first_valid", C_INST_VALID, 10);
    chk("t6_first_pc", bus.pcDir, RESET_PC);
    chk("t6_first_ins", bus.instruction, tag(RESET_PC));
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
